// File: rtl/memory_access_ctrl.sv
// Command-driven initiator for the 16x8 one-hot register file.
// Sequences SETUP/STROBE/HOLD so WE never overlaps a select or data change.
module memory_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic [1:0]  CmdOp,
    input  logic [3:0]  CmdAddr,
    input  logic [7:0]  CmdData,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [7:0]  RspData,
    output logic        MemWE,
    output logic [7:0]  MemDataToWrite,
    output logic [15:0] MemRegSel,
    input  logic [7:0]  MemReadData
);

    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, HOLD, RESP
    } stateT;

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpRmw   = 2'b10;
    localparam logic [1:0] OpFill  = 2'b11;

    stateT      state;
    logic [1:0] op;
    logic [3:0] addr;

    assign CmdReady = rst_n && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            op             <= OpRead;
            addr           <= 4'd0;
            MemWE          <= 1'b0;
            MemRegSel      <= 16'h0000;
            MemDataToWrite <= 8'h00;
            RspValid       <= 1'b0;
            RspData        <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (CmdValid) begin
                        op             <= CmdOp;
                        MemDataToWrite <= CmdData;
                        RspData        <= CmdData;
                        state          <= SETUP;
                        if (CmdOp == OpFill) begin
                            addr      <= 4'd0;
                            MemRegSel <= 16'h8000;
                        end else begin
                            addr      <= CmdAddr;
                            MemRegSel <= 16'h8000 >> CmdAddr;
                        end
                    end
                end
                SETUP: begin
                    unique case (op)
                        OpRead: begin
                            RspData   <= MemReadData;
                            MemRegSel <= 16'h0000;
                            RspValid  <= 1'b1;
                            state     <= RESP;
                        end
                        OpRmw: begin
                            // Old value is reported; the sum wraps mod 256.
                            RspData        <= MemReadData;
                            MemDataToWrite <= MemReadData + MemDataToWrite;
                            MemWE          <= 1'b1;
                            state          <= STROBE;
                        end
                        OpWrite, OpFill: begin
                            MemWE <= 1'b1;
                            state <= STROBE;
                        end
                        default: state <= IDLE;
                    endcase
                end
                STROBE: begin
                    MemWE <= 1'b0;
                    state <= HOLD;
                end
                HOLD: begin
                    if (op == OpFill && addr != 4'd15) begin
                        addr      <= addr + 4'd1;
                        MemRegSel <= MemRegSel >> 1;
                        state     <= SETUP;
                    end else begin
                        MemRegSel <= 16'h0000;
                        RspValid  <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Bench for memory_access_ctrl with a behavioural register file model
// and a response scoreboard.
module tb_memory_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        CmdValid;
    logic        CmdReady;
    logic [1:0]  CmdOp;
    logic [3:0]  CmdAddr;
    logic [7:0]  CmdData;
    logic        RspValid;
    logic        RspReady;
    logic [7:0]  RspData;
    logic        MemWE;
    logic [7:0]  MemDataToWrite;
    logic [15:0] MemRegSel;
    logic [7:0]  MemReadData;

    memory_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .CmdValid(CmdValid), .CmdReady(CmdReady),
        .CmdOp(CmdOp), .CmdAddr(CmdAddr), .CmdData(CmdData),
        .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData),
        .MemWE(MemWE), .MemDataToWrite(MemDataToWrite),
        .MemRegSel(MemRegSel), .MemReadData(MemReadData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [16];

    always_comb begin
        MemReadData = 8'h00;
        for (int i = 0; i < 16; i++)
            if (MemRegSel[15-i]) MemReadData = MemReadData | mem[i];
    end

    always @(posedge clk)
        if (MemWE)
            for (int i = 0; i < 16; i++)
                if (MemRegSel[15-i]) mem[i] <= MemDataToWrite;

    int total = 0;
    int bad = 0;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic        prevWE;
    logic [15:0] prevSel;
    logic [7:0]  prevData;
    logic [15:0] weSels [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            prevWE   = 1'b0;
            prevSel  = 16'h0;
            prevData = 8'h0;
        end else begin
            checkVal("selOneHot0", 32'($onehot0(MemRegSel)), 1);
            if (MemWE) begin
                checkVal("weOneHot", 32'($onehot(MemRegSel)), 1);
                checkVal("selPreWE", MemRegSel, prevSel);
                weSels.push_back(MemRegSel);
            end
            if (prevWE) begin
                checkVal("selPostWE", MemRegSel, prevSel);
                checkVal("dataPostWE", MemDataToWrite, prevData);
            end
            prevWE   = MemWE;
            prevSel  = MemRegSel;
            prevData = MemDataToWrite;
        end
    end

    logic [7:0] sb [$];
    int lastAcc;

    localparam logic [1:0] RD = 2'b00;
    localparam logic [1:0] WR = 2'b01;
    localparam logic [1:0] RMW = 2'b10;
    localparam logic [1:0] FILL = 2'b11;

    task automatic acceptCmd(input logic [1:0] op, input logic [3:0] a,
                             input logic [7:0] d);
        int n = 0;
        while (!CmdReady && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!CmdReady) checkVal("cmdReadyTimeout", 0, 1);
        CmdValid = 1'b1;
        CmdOp    = op;
        CmdAddr  = a;
        CmdData  = d;
        @(posedge clk); #1;
        CmdValid = 1'b0;
        lastAcc  = cyc;
    endtask

    task automatic doCmd(input string tag, input logic [1:0] op,
                         input logic [3:0] a, input logic [7:0] d,
                         input logic [7:0] exp, input int expLat);
        int n = 0;
        logic [7:0] e;
        sb.push_back(exp);
        acceptCmd(op, a, d);
        while (!RspValid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        e = sb.pop_front();
        if (!RspValid) begin
            checkVal({tag, "Timeout"}, 0, 1);
        end else begin
            checkVal({tag, "Lat"}, cyc - lastAcc + 1, expLat);
            checkVal(tag, RspData, e);
            if (RspReady) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        int acc0;
        int n;
        logic ok;
        rst_n    = 1'b0;
        CmdValid = 1'b0;
        CmdOp    = 2'b00;
        CmdAddr  = 4'd0;
        CmdData  = 8'h00;
        RspReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rstWE", MemWE, 0);
        checkVal("rstSel", MemRegSel, 0);
        checkVal("rstData", MemDataToWrite, 0);
        checkVal("rstRspValid", RspValid, 0);
        checkVal("rstRspData", RspData, 0);
        checkVal("rstCmdReady", CmdReady, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checkVal("readyAfterRst", CmdReady, 1);

        weSels.delete();
        doCmd("wr3", WR, 4'd3, 8'hA5, 8'hA5, 4);
        checkVal("wr3Pulses", weSels.size(), 1);
        if (weSels.size() > 0) checkVal("wr3Sel", weSels[0], 16'h1000);
        doCmd("rd3", RD, 4'd3, 8'h00, 8'hA5, 2);

        weSels.delete();
        doCmd("fill", FILL, 4'd9, 8'h5A, 8'h5A, 49);
        checkVal("fillPulses", weSels.size(), 16);
        ok = (weSels.size() == 16);
        for (int i = 0; i < 16 && ok; i++)
            if (weSels[i] != (16'h8000 >> i)) ok = 1'b0;
        checkVal("fillWalk", ok, 1);
        doCmd("rd0", RD, 4'd0, 8'h00, 8'h5A, 2);
        acc0 = lastAcc;
        doCmd("rd15", RD, 4'd15, 8'h00, 8'h5A, 2);
        checkVal("rdSpacing", lastAcc - acc0, 3);

        doCmd("wr7", WR, 4'd7, 8'hF0, 8'hF0, 4);
        doCmd("rmw7", RMW, 4'd7, 8'h20, 8'hF0, 4);
        doCmd("rd7", RD, 4'd7, 8'h00, 8'h10, 2);

        RspReady = 1'b0;
        doCmd("rdHold", RD, 4'd7, 8'h00, 8'h10, 2);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                CmdValid = 1'b1;
                CmdOp    = WR;
                CmdAddr  = 4'd9;
                CmdData  = 8'hEE;
            end
            if (i == 4) CmdValid = 1'b0;
            checkVal("holdValid", RspValid, 1);
            checkVal("holdData", RspData, 8'h10);
            checkVal("holdReady", CmdReady, 0);
            @(posedge clk); #1;
        end
        RspReady = 1'b1;
        @(posedge clk); #1;
        checkVal("holdRelease", RspValid, 0);
        doCmd("rd9", RD, 4'd9, 8'h00, 8'h5A, 2);

        doCmd("wr5", WR, 4'd5, 8'h77, 8'h77, 4);
        acceptCmd(FILL, 4'd0, 8'h3C);
        n = 0;
        while (!(MemWE && MemRegSel == 16'h0800) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        checkVal("fill5thStrobe", MemRegSel, 16'h0800);
        rst_n = 1'b0;
        #1;
        checkVal("abortWE", MemWE, 0);
        checkVal("abortSel", MemRegSel, 0);
        checkVal("abortRsp", RspValid, 0);
        checkVal("abortReady", CmdReady, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkVal("noAbortRsp", RspValid, 0);
        doCmd("rdAfter3", RD, 4'd3, 8'h00, 8'h3C, 2);
        doCmd("rdAfter4", RD, 4'd4, 8'h00, 8'h5A, 2);
        doCmd("rdAfter5", RD, 4'd5, 8'h00, 8'h77, 2);

        checkVal("sbEmpty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
